// File: rtl/serial_stim_tx.sv
// Moore parallel-to-serial transmitter: loads a WIDTH-bit word on start/ready,
// shifts it out one bit per clock (stallable with hold) and pulses done after the last bit.
module serial_stim_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             hold,
  output logic             ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [1:0]       state_out
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Move the next bit onto the output end of the register, zero-filling behind it.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE so a frame is never reloaded.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!hold) begin
          shreg_d = shift_toward_out(shreg_q);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only.
  assign ready     = (state_q == ST_IDLE);
  assign bit_valid = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign bit_out   = bit_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
  assign state_out = state_q;

endmodule

// File: doc/serial_stim_tx.md
Name: serial_stim_tx

Overview:
Moore-style parallel-to-serial transmitter. It produces the single-bit serial input stream consumed by the lab's serial-input FSM blocks.
- Accepts a WIDTH-bit word through a start/ready handshake.
- Emits the word one bit per clock, with a hold (stall) input.
- Pulses done after the last bit.
- All outputs are decoded from registered state only (Moore).

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  single system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  WIDTH  word to transmit; sampled only on an accepted start.
start  input  1  request to transmit; accepted only when ready=1.
hold  input  1  stall; freezes shifting while high.
ready  output  1  high in IDLE; block can accept start.
bit_out  output  1  current serial bit; 0 outside SHIFT.
bit_valid  output  1  high in SHIFT; bit_out is meaningful.
done  output  1  one-cycle pulse after the last bit.
state_out  output  2  encoded state, for debug.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset); it acts immediately, without waiting for clk.
- Internal registers:
  - state (2b): IDLE=00, SHIFT=01, DONE=10; 11 is illegal and goes to IDLE next cycle.
  - shreg (WIDTH).
  - cnt (ceil(log2(WIDTH)) bits).
- Reset values: state=IDLE, shreg=0, cnt=0. This gives ready=1, bit_out=0, bit_valid=0, done=0, state_out=00.
- Outputs are pure functions of the registers. No combinational path exists from start, hold or data_in to any output.
  - ready = (state==IDLE).
  - bit_valid = (state==SHIFT).
  - done = (state==DONE).
  - bit_out = bit_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
- IDLE:
  - start=1 at a rising edge: shreg<=data_in, cnt<=0, state<=SHIFT.
  - start=0: remain in IDLE.
  - hold is ignored in IDLE.
- SHIFT, hold=0 at an edge:
  - shreg shifts toward the output end (left if MSB_FIRST, else right), zero-filling.
  - cnt<=cnt+1.
  - If cnt==WIDTH-1, state<=DONE instead (shreg/cnt values are then don't-care).
- SHIFT, hold=1 at an edge: state, shreg and cnt all hold. bit_out repeats the same bit and bit_valid stays 1.
- Sink rule: the downstream consumer takes exactly one bit per edge where bit_valid=1 and hold=0.
- start is ignored in SHIFT and DONE. A word is never truncated or reloaded mid-frame.
- DONE: lasts exactly one cycle, then state<=IDLE unconditionally; hold is ignored.
- Latency:
  - Start accepted at edge k: first bit visible in cycle k+1.
  - With no holds, bits occupy cycles k+1..k+WIDTH, done in k+WIDTH+1, ready=1 in k+WIDTH+2.
  - Each cycle with hold=1 during SHIFT adds one cycle.
- Back-to-back frames: start held high gives a 2-cycle gap (DONE, IDLE) between frames. The new word is sampled at the IDLE edge.
- Reset mid-frame: immediate return to IDLE. The partial frame is discarded; no done pulse is generated.
- data_in may change freely after acceptance.

Test Plan:
1. Assert reset for 3 cycles with random inputs -> ready=1, bit_out=0, bit_valid=0, done=0, state_out=00 throughout, including asynchronously mid-cycle.
2. WIDTH=8, MSB_FIRST=1, data_in=8'hB4, start for 1 cycle, hold=0 -> bit_out=1,0,1,1,0,1,0,0 with bit_valid=1 for 8 consecutive cycles; then done=1 for 1 cycle; then ready=1.
3. MSB_FIRST=0, data_in=8'hB4 -> bit_out=0,0,1,0,1,1,0,1; done exactly 9 cycles after the accepting edge.
4. data_in=8'hB4, MSB_FIRST=1, hold=1 during the 3rd and 4th bit cycles -> 3rd bit (1) shown for 3 cycles; sequence sampled on hold=0 edges is still 1,0,1,1,0,1,0,0; done 2 cycles later than in test 2.
5. Pulse start with data_in=8'hFF during SHIFT of frame 8'h0F -> frame 8'h0F completes unaltered and the second start is ignored. Then hold start high with data_in=8'h81 -> exactly 2 idle cycles between frames.
6. Assert reset after the 5th bit of 8'hB4 -> outputs reset immediately with no done pulse. After release plus start with 8'h55, output is 0,1,0,1,0,1,0,1 cleanly.
